// File: rtl/mips_regfile_sb.sv
// -----------------------------------------------------------------------------
// mips_regfile_sb
//   MIPS general-purpose register file with a per-register scoreboard of
//   pending-write bits. It has two combinational read ports and one synchronous
//   write port. Register 0 reads as zero and can never be written or reserved.
//   Issue reserves a destination with rsv_en/rsv_addr. Writeback writes the
//   result and releases the reservation. flush drops every reservation.
//
//   Parameters
//     DATA_W    register width in bits
//     ADDR_W    address width, depth = 2**ADDR_W
//
//   Ports
//     clk                rising-edge clock
//     rst                asynchronous active-low reset
//     ra1/rd1/rbusy1     read port 1: address, data, pending flag
//     ra2/rd2/rbusy2     read port 2: address, data, pending flag
//     we/wa/wd           write port: enable, address, data
//     rsv_en/rsv_addr    reserve a destination register (set pending)
//     flush              clear all pending bits
//     busy_cnt           registered count of pending registers
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, a write to the address on a read port
//                        is forwarded to that port in the same cycle, with
//                        rbusy forced low.
// -----------------------------------------------------------------------------
module mips_regfile_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ra1,
   output logic [DATA_W-1:0] rd1,
   output logic              rbusy1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd2,
   output logic              rbusy2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              flush,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic [DEPTH-1:0]  pending_nxt;
   logic [CNT_W-1:0]  busy_cnt_nxt;
   logic              wr_hit;
   logic              rsv_hit;
   logic              cnt_inc;
   logic              cnt_dec;

   // Qualified write/reserve strobes and scoreboard next state
   always_comb begin : next_state
      wr_hit       = we && (wa != '0);
      // A flush in the same cycle discards the reservation.
      rsv_hit      = rsv_en && (rsv_addr != '0) && !flush;
      // Counter moves only on real 0->1 / 1->0 transitions. When the write and
      // the reserve hit the same register, the new producer keeps it pending.
      cnt_inc      = rsv_hit && !pending[rsv_addr];
      cnt_dec      = wr_hit && pending[wa] && !(rsv_hit && (rsv_addr == wa));

      pending_nxt  = pending;
      busy_cnt_nxt = busy_cnt;

      if (wr_hit) begin
         pending_nxt[wa] = 1'b0;
      end
      if (rsv_hit) begin
         pending_nxt[rsv_addr] = 1'b1;
      end
      if (flush) begin
         pending_nxt = '0;
      end
      pending_nxt[0] = 1'b0;

      if (flush) begin
         busy_cnt_nxt = '0;
      end else if (cnt_inc && !cnt_dec && (busy_cnt != CNT_MAX)) begin
         busy_cnt_nxt = busy_cnt + CNT_W'(1);
      end else if (cnt_dec && !cnt_inc && (busy_cnt != '0)) begin
         busy_cnt_nxt = busy_cnt - CNT_W'(1);
      end
   end

   // Scoreboard and counter state
   always_ff @(posedge clk or negedge rst) begin : sb_reg
      if (!rst) begin
         pending  <= '0;
         busy_cnt <= '0;
      end else begin
         pending  <= pending_nxt;
         busy_cnt <= busy_cnt_nxt;
      end
   end

   // Data array, one register per entry. Entry 0 never sees a write enable.
   for (genvar i = 0; i < DEPTH; i++) begin : g_mem
      always_ff @(posedge clk or negedge rst) begin : mem_reg
         if (!rst) begin
            mem[i] <= '0;
         end else if (wr_hit && (wa == ADDR_W'(i))) begin
            mem[i] <= wd;
         end
      end
   end

   // Combinational read ports with optional write forwarding
   always_comb begin : read_ports
      rd1    = (ra1 == '0) ? '0 : mem[ra1];
      rbusy1 = pending[ra1];
      rd2    = (ra2 == '0) ? '0 : mem[ra2];
      rbusy2 = pending[ra2];
`ifdef REGFILE_BYPASS_EN
      // While rst is low, reads must stay zero, so forwarding is blocked.
      if (rst && wr_hit && (wa == ra1)) begin
         rd1    = wd;
         rbusy1 = 1'b0;
      end
      if (rst && wr_hit && (wa == ra2)) begin
         rd2    = wd;
         rbusy2 = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_mips_regfile_sb
//   Scoreboard bench for mips_regfile_sb. Each driven cycle pushes the expected
//   read-port and counter values, computed by a behavioural model, into a queue.
//   The monitor step pops that entry and compares it with the DUT outputs.
//   Directed checks cover reset, register 0, counter sequencing, same-cycle
//   write+reserve, flush, counter ceiling and forwarding.
// -----------------------------------------------------------------------------
module tb_mips_regfile_sb;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] ra1, ra2, wa, rsv_addr;
   logic [DATA_W-1:0] rd1, rd2, wd;
   logic              rbusy1, rbusy2, we, rsv_en, flush;
   logic [CNT_W-1:0]  busy_cnt;

   mips_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .ra1      (ra1),
      .rd1      (rd1),
      .rbusy1   (rbusy1),
      .ra2      (ra2),
      .rd2      (rd2),
      .rbusy2   (rbusy2),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .flush    (flush),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] rd1;
      logic              rb1;
      logic [DATA_W-1:0] rd2;
      logic              rb2;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   exp_t              sbq[$];
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic [DEPTH-1:0]  m_pend;
   int                checks = 0;
   int                errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_pend = '0;
   endtask

   // Expected outputs for the current model state and currently driven inputs
   function automatic exp_t model_exp();
      exp_t e;
      e.rd1 = (ra1 == 0) ? '0 : m_mem[ra1];
      e.rb1 = (ra1 == 0) ? 1'b0 : m_pend[ra1];
      e.rd2 = (ra2 == 0) ? '0 : m_mem[ra2];
      e.rb2 = (ra2 == 0) ? 1'b0 : m_pend[ra2];
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 0 && wa == ra1) begin e.rd1 = wd; e.rb1 = 1'b0; end
      if (we && wa != 0 && wa == ra2) begin e.rd2 = wd; e.rb2 = 1'b0; end
`endif
      e.cnt = CNT_W'($countones(m_pend));
      return e;
   endfunction

   task automatic monitor();
      exp_t e;
      if (sbq.size() == 0) begin
         check("sb_empty", 64'(1), 64'(0));
         return;
      end
      e = sbq.pop_front();
      check("rd1", 64'(rd1), 64'(e.rd1));
      check("rbusy1", 64'(rbusy1), 64'(e.rb1));
      check("rd2", 64'(rd2), 64'(e.rd2));
      check("rbusy2", 64'(rbusy2), 64'(e.rb2));
      check("busy_cnt", 64'(busy_cnt), 64'(e.cnt));
   endtask

   // Drive one cycle's inputs at the falling edge, then score the outputs
   task automatic drive(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic r, input logic [ADDR_W-1:0] ra, input logic f,
                        input logic [ADDR_W-1:0] p1, input logic [ADDR_W-1:0] p2);
      @(negedge clk);
      we = w; wa = a; wd = d; rsv_en = r; rsv_addr = ra; flush = f; ra1 = p1; ra2 = p2;
      #1 sbq.push_back(model_exp());
      #1 monitor();
   endtask

   // Advance through the rising edge and update the model from the driven inputs
   task automatic tick();
      logic w, r, f;
      logic [ADDR_W-1:0] a, ra;
      logic [DATA_W-1:0] d;
      w = we; a = wa; d = wd; r = rsv_en; ra = rsv_addr; f = flush;
      @(posedge clk);
      if (w && a != 0) begin m_mem[a] = d; m_pend[a] = 1'b0; end
      if (r && ra != 0 && !f) m_pend[ra] = 1'b1;
      if (f) m_pend = '0;
   endtask

   task automatic cyc(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic r, input logic [ADDR_W-1:0] ra, input logic f,
                      input logic [ADDR_W-1:0] p1, input logic [ADDR_W-1:0] p2);
      drive(w, a, d, r, ra, f, p1, p2);
      tick();
   endtask

   initial begin
      rst = 1'b0;
      we = 1'b0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
      ra1 = '0; ra2 = '0;
      model_clear();

      // Power-on reset
      repeat (2) @(negedge clk);
      ra1 = 5'd5; ra2 = 5'd7;
      #1;
      check("por_rd1", 64'(rd1), 64'(0));
      check("por_rbusy2", 64'(rbusy2), 64'(0));
      check("por_cnt", 64'(busy_cnt), 64'(0));
      rst = 1'b1;

      // Register 0: write and reserve are both ignored
      cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      check("r0_rd1", 64'(rd1), 64'(0));
      check("r0_rbusy1", 64'(rbusy1), 64'(0));
      check("r0_cnt", 64'(busy_cnt), 64'(0));
      tick();

      // Counter sequencing: reserve r3, r4, r3, then write r3
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd4);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd4);
      check("seq_cnt1", 64'(busy_cnt), 64'(1));
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd4);
      check("seq_cnt2", 64'(busy_cnt), 64'(2));
      tick();
      drive(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4);
      check("seq_cnt2b", 64'(busy_cnt), 64'(2));
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4);
      check("seq_cnt_rel", 64'(busy_cnt), 64'(1));
      check("seq_rd_r3", 64'(rd1), 64'(32'hA5));
      check("seq_rbusy_r3", 64'(rbusy1), 64'(0));
      tick();

      // Same-cycle write and reserve on an already pending register
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
      cyc(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
      check("sim_rd", 64'(rd1), 64'(32'h55));
      check("sim_rbusy", 64'(rbusy1), 64'(1));
      check("sim_cnt", 64'(busy_cnt), 64'(2));
      tick();

      // Flush with a reserve in the same cycle
      for (int i = 10; i < 14; i++) cyc(1'b0, 5'd0, 32'h0, 1'b1, ADDR_W'(i), 1'b0, 5'd12, 5'd9);
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd12, 5'd9);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd9);
      check("flush_cnt", 64'(busy_cnt), 64'(0));
      check("flush_rbusy", 64'(rbusy1), 64'(0));
      tick();

      // Counter ceiling: every non-zero register reserved, then one re-reserved
      for (int i = 1; i < DEPTH; i++) cyc(1'b0, 5'd0, 32'h0, 1'b1, ADDR_W'(i), 1'b0, ADDR_W'(i), 5'd0);
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd31);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd31);
      check("max_cnt", 64'(busy_cnt), 64'(DEPTH - 1));
      tick();
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0);

      // Forwarding: r2 pending with 0x10, then written with 0x99
      cyc(1'b1, 5'd2, 32'h10, 1'b0, 5'd0, 1'b0, 5'd2, 5'd2);
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd2, 5'd2);
      drive(1'b1, 5'd2, 32'h99, 1'b0, 5'd0, 1'b0, 5'd2, 5'd2);
`ifdef REGFILE_BYPASS_EN
      check("byp_rd1", 64'(rd1), 64'(32'h99));
      check("byp_rd2", 64'(rd2), 64'(32'h99));
      check("byp_rbusy1", 64'(rbusy1), 64'(0));
      check("byp_rbusy2", 64'(rbusy2), 64'(0));
`else
      check("nobyp_rd1", 64'(rd1), 64'(32'h10));
      check("nobyp_rd2", 64'(rd2), 64'(32'h10));
      check("nobyp_rbusy1", 64'(rbusy1), 64'(1));
      check("nobyp_rbusy2", 64'(rbusy2), 64'(1));
`endif
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd2);
      check("byp_next_rd1", 64'(rd1), 64'(32'h99));
      check("byp_next_rbusy1", 64'(rbusy1), 64'(0));
      tick();

      // Randomised traffic on a narrow address range to force collisions
      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom(),
             1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
             ($urandom_range(0, 19) == 0),
             ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
      end

      // Reset mid-cycle discards data and reservations immediately
      cyc(1'b1, 5'd5, 32'h1234, 1'b1, 5'd7, 1'b0, 5'd5, 5'd7);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
      #1 rst = 1'b0;
      #1;
      check("mrst_rd1", 64'(rd1), 64'(0));
      check("mrst_rbusy2", 64'(rbusy2), 64'(0));
      check("mrst_cnt", 64'(busy_cnt), 64'(0));
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);

      check("sb_drained", 64'(sbq.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_regfile_sb.md
# mips_regfile_sb

Parametrised MIPS general-purpose register file with two asynchronous read ports, one synchronous write port, a hardwired-zero register 0 and a per-register scoreboard of pending-write bits. It sits in the decode stage: decode reads operands and checks busy bits, issue reserves the destination register, and writeback writes the result and releases the reservation. It replaces the fixed 32x32 file and adds hazard tracking that the pipeline uses to stall on load-use and multi-cycle results.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- ra1  input  ADDR_W  read port 1 address
- rd1  output  DATA_W  read port 1 data (combinational)
- rbusy1  output  1  register at ra1 has a pending write
- ra2  input  ADDR_W  read port 2 address
- rd2  output  DATA_W  read port 2 data (combinational)
- rbusy2  output  1  register at ra2 has a pending write
- we  input  1  write enable
- wa  input  ADDR_W  write address
- wd  input  DATA_W  write data
- rsv_en  input  1  reserve destination (set pending bit)
- rsv_addr  input  ADDR_W  destination register to reserve
- flush  input  1  clear all pending bits (pipeline flush)
- busy_cnt  output  ADDR_W+1  number of registers currently pending (registered)

## Operation
- Storage: 2**ADDR_W x DATA_W data array, 2**ADDR_W pending bits, busy_cnt counter.
- Register 0: always reads 0, rbusy always 0; writes and reservations to address 0 ignored; pending[0] never set.
- Write: we=1, wa!=0 -> mem[wa] <= wd; pending[wa] cleared, unless reserved in the same cycle.
- Write to a non-pending register is legal: data updated, counter unchanged.
- Reserve: rsv_en=1, rsv_addr!=0 -> pending[rsv_addr] <= 1. Reserving an already-pending register: stays pending, counter unchanged.
- Write and reserve to same address in same cycle: data written, pending stays/becomes 1 (new producer wins).
- flush=1: all pending bits cleared, busy_cnt <= 0; any reserve in the same cycle discarded; a write in the same cycle still updates data.
- busy_cnt next = busy_cnt + (reserve sets a previously clear bit) - (write clears a previously set bit, different address from reserve). Never exceeds 2**ADDR_W-1; never underflows.
- Reads: rd = mem[ra], rbusy = pending[ra], both combinational from current state (see Configuration for bypass).

## Timing
- Reset (rst=0, asynchronous): all registers 0, all pending 0, busy_cnt 0; rd1/rd2 read 0, rbusy1/rbusy2 0 immediately. Deassertion synchronous to clk handled upstream.
- Write latency: visible on read ports the cycle after the write edge (without bypass).
- Reserve latency: rbusy asserts the cycle after the rsv_en edge.
- Release: rbusy deasserts the cycle after the write edge (same cycle with bypass).
- busy_cnt valid one cycle after the causing event.
- Reset mid-operation: discards all pending state and data; no partial updates.

## Configuration
- REGFILE_BYPASS_EN defined: when we=1, wa!=0 and wa==ra, that port returns wd and rbusy=0 in the same cycle (write-to-read forwarding); reservation in the same cycle does not affect the forwarded rbusy.
- Undefined: no forwarding; read ports reflect only registered state; rbusy clears one cycle after write.

## Test plan
- Reset: write mem[5]=0x1234 and reserve r7, assert rst=0 mid-cycle -> rd of r5=0, rbusy of r7=0, busy_cnt=0 immediately.
- Register 0: we=1, wa=0, wd=0xFFFFFFFF and rsv_en on r0 -> rd1(ra1=0)=0, rbusy1=0, busy_cnt=0.
- Scoreboard: reserve r3, r4, r3 on consecutive cycles -> busy_cnt 1,2,2; write r3=0xA5 -> busy_cnt=1, rbusy(r3)=0, rd=0xA5 next cycle.
- Simultaneous: r9 pending, write r9=0x55 and reserve r9 same cycle -> rd=0x55, rbusy=1, busy_cnt unchanged.
- Flush: 4 registers pending, flush=1 with rsv_en on r12 -> busy_cnt=0, rbusy(r12)=0 next cycle.
- Bypass (REGFILE_BYPASS_EN): r2 pending holding 0x10, write r2=0x99 with ra1=ra2=2 -> rd1=rd2=0x99, rbusy1=rbusy2=0 same cycle; without macro -> 0x10, rbusy=1 that cycle, 0x99/0 next.
